// File: rtl/na_pkg.sv
// na_pkg -- shared definitions for the number analyzer.
//
// Contents:
//   na_state_e            controller states IDLE / SCAN / DONE
//   ZERO, ODD, DIV3, POW2 bit positions inside out_flags
//   OP_W                  operand width (32)
//   CNT_W                 width of the set-bit counter. It depends on the
//                         optional feature macro NA_POPCOUNT_EN:
//                         6 bits (full 0..32 count) when defined, otherwise a
//                         2-bit saturating count (0, 1, >=2).
package na_pkg;

    localparam int OP_W = 32;

    // Positions of the result flags inside out_flags.
    localparam int ZERO = 0;
    localparam int ODD  = 1;
    localparam int DIV3 = 2;
    localparam int POW2 = 3;

`ifdef NA_POPCOUNT_EN
    localparam int CNT_W = 6;
`else
    localparam int CNT_W = 2;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } na_state_e;

endpackage

// File: rtl/na_mod3_step.sv
// na_mod3_step -- one step of an MSB-first mod-3 reduction.
//
// Shifting one more bit into a number multiplies the value seen so far by 2
// and adds the bit, so the running residue evolves as (2*r + b) mod 3.
// Purely combinational.
//
// Ports:
//   residue       in   2  current residue (0..2)
//   bit_in        in   1  next operand bit, MSB first
//   residue_next  out  2  (2*residue + bit_in) mod 3
module na_mod3_step (
    input  logic [1:0] residue,
    input  logic       bit_in,
    output logic [1:0] residue_next
);

    always_comb begin
        residue_next = 2'd0;
        case ({residue, bit_in})
            3'd0:    residue_next = 2'd0;
            3'd1:    residue_next = 2'd1;
            3'd2:    residue_next = 2'd2;
            3'd3:    residue_next = 2'd0;
            3'd4:    residue_next = 2'd1;
            3'd5:    residue_next = 2'd2;
            // Residue 3 is unreachable; fold it as if it were 0 (6 mod 3 = 0).
            3'd6:    residue_next = 2'd0;
            default: residue_next = 2'd1;
        endcase
    end

endmodule

// File: rtl/number_analyzer_ctrl.sv
// number_analyzer_ctrl -- bit-serial classifier for a 32-bit unsigned operand.
//
// An operand is accepted in IDLE, then scanned one bit per clock MSB first
// (32 clocks), keeping a mod-3 residue and a set-bit count. The result is
// held in DONE until the consumer takes it.
//
// Optional feature macro: NA_POPCOUNT_EN
//   defined   -> full 6-bit set-bit count, exposed on out_popcnt
//   undefined -> out_popcnt absent; 2-bit saturating count feeds is_pow2 only
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   abort       in   1   synchronous cancel, overrides everything else
//   in_valid    in   1   operand offered
//   in_ready    out  1   high in IDLE
//   in_data     in   32  operand, unsigned
//   out_valid   out  1   high in DONE
//   out_ready   in   1   consumer takes the result
//   out_flags   out  4   {is_pow2, is_div3, is_odd, is_zero}; 0 outside DONE
//   out_popcnt  out  6   set-bit count (NA_POPCOUNT_EN only); 0 outside DONE
//   busy        out  1   high in SCAN or DONE
module number_analyzer_ctrl
    import na_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_flags,
`ifdef NA_POPCOUNT_EN
    output logic [5:0]      out_popcnt,
`endif
    output logic            busy
);

    na_state_e        state_q, state_d;
    logic [OP_W-1:0]  op_q,    op_d;
    logic [4:0]       idx_q,   idx_d;
    logic [1:0]       res_q,   res_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             cur_bit;
    logic [1:0]       res_step;

    assign cur_bit = op_q[idx_q];

    na_mod3_step u_mod3_step (
        .residue      (res_q),
        .bit_in       (cur_bit),
        .residue_next (res_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    idx_d   = 5'd31;
                    res_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                res_d = res_step;
`ifdef NA_POPCOUNT_EN
                if (cur_bit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                // Only "exactly one bit set" matters, so stop counting at 2.
                if (cur_bit && (cnt_q != CNT_W'(2))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                // The index stops at 0 instead of wrapping; that bit is the last.
                if (idx_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cancel wins over capture and over the output handshake; the
        // operation's partial state is simply left behind and overwritten
        // by the next capture.
        if (abort) begin
            state_d = IDLE;
            op_d    = op_q;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        out_flags = 4'b0000;
        if (state_q == DONE) begin
            out_flags[ZERO] = (op_q == '0);
            out_flags[ODD]  = op_q[0];
            out_flags[DIV3] = (res_q == 2'd0);
            out_flags[POW2] = (cnt_q == CNT_W'(1));
        end
    end

`ifdef NA_POPCOUNT_EN
    assign out_popcnt = (state_q == DONE) ? cnt_q : 6'd0;
`endif

endmodule

// File: tb/tb_number_analyzer_ctrl.sv
// tb_number_analyzer_ctrl -- scoreboard bench for number_analyzer_ctrl.
//
// The driver pushes the expected result of every accepted operand into a
// queue; an independent monitor on the falling edge pops and compares at
// each output handshake, and also checks latency, hold stability and the
// in_ready behaviour around DONE. Works with or without NA_POPCOUNT_EN.
module tb_number_analyzer_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        abort     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_data   = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_flags;
    logic        busy;
`ifdef NA_POPCOUNT_EN
    logic [5:0]  out_popcnt;
`endif

    number_analyzer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flags  (out_flags),
`ifdef NA_POPCOUNT_EN
        .out_popcnt (out_popcnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] op;
        logic [3:0]  flags;
        logic [5:0]  pop;
        int          cap;
    } exp_t;
    exp_t exp_q[$];

    // 0: random out_ready, 1: held low, 2: held high
    int ready_mode = 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: classify the operand directly from its arithmetic value.
    function automatic logic [3:0] model_flags(input logic [31:0] v);
        logic [3:0] f;
        f[0] = (v == 32'd0);
        f[1] = (v % 2) == 1;
        f[2] = (v % 3) == 0;
        f[3] = ($countones(v) == 1);
        return f;
    endfunction

    function automatic logic [5:0] model_pop(input logic [31:0] v);
        return 6'($countones(v));
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom % 2) == 1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Offer one operand; record the expected result once the capture edge
    // is certain (seen ready at the falling edge before it).
    task automatic send_exp(input logic [31:0] op, input logic [3:0] flags, input logic [5:0] pop);
        exp_t e;
        bit   got = 0;
        @(posedge clk) #1;
        in_data  = op;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (in_ready && !abort && rst_n) begin
                e.op = op; e.flags = flags; e.pop = pop; e.cap = cyc + 1;
                exp_q.push_back(e);
                got = 1;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] op);
        send_exp(op, model_flags(op), model_pop(op));
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor
    bit         seen = 0;
    bit         pend = 0;
    logic [3:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
            pend = 0;
        end else begin
            if (pend) begin
                chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
                pend = 0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        held = out_flags;
                        chk("latency", 32'(cyc - exp_q[0].cap), 32'd32);
                    end else begin
                        chk("flags_stable", {28'd0, out_flags}, {28'd0, held});
                    end
                    chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                    chk("busy_in_done", {31'd0, busy}, 32'd1);
                    if (out_ready && !abort) begin
                        chk("flags", {28'd0, out_flags}, {28'd0, exp_q[0].flags});
`ifdef NA_POPCOUNT_EN
                        chk("popcnt", {26'd0, out_popcnt}, {26'd0, exp_q[0].pop});
`endif
                        $display("txn op=%08h flags=%b expected=%b", exp_q[0].op, out_flags, exp_q[0].flags);
                        void'(exp_q.pop_front());
                        seen = 0;
                        pend = 1;
                    end
                end
            end else begin
                seen = 0;
                if (out_flags !== 4'b0000) chk("flags_zero_outside_done", {28'd0, out_flags}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit          got_valid;

        // Reset state
        @(negedge clk);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_flags",     {28'd0, out_flags}, 32'd0);
        @(posedge clk) #3;
        rst_n = 1'b1;

        // Directed operands with literal expectations
        ready_mode = 2;
        send_exp(32'hFFFF_FFFF, 4'b0110, 6'd32);
        wait_drain();
        send_exp(32'h0000_0000, 4'b0101, 6'd0);
        wait_drain();
        send_exp(32'h8000_0001, 4'b0110, 6'd2);
        wait_drain();
        send_exp(32'h8000_0000, 4'b1000, 6'd1);
        wait_drain();

        // Backpressure: hold out_ready low for 10 cycles in DONE
        ready_mode = 1;
        send(32'h0000_0040);
        got_valid = 0;
        for (int i = 0; i < 60 && !got_valid; i++) begin
            @(negedge clk);
            got_valid = out_valid;
        end
        chk("bp_reach_done", {31'd0, got_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        ready_mode = 2;
        wait_drain();

        // Abort on the 10th SCAN cycle with in_valid high
        send_exp(32'h1234_5678, 4'b0000, 6'd0);
        repeat (9) @(posedge clk);
        #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0007;
        exp_q.delete();
        @(posedge clk) #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready},  32'd1);
        chk("abort_busy",     {31'd0, busy},      32'd0);
        chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);

        // Abort together with in_valid in IDLE: no capture
        @(posedge clk) #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0005;
        @(posedge clk) #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_abort_no_capture", {31'd0, busy}, 32'd0);
        send_exp(32'h0000_0003, 4'b0110, 6'd2);
        wait_drain();

        // Asynchronous reset mid-SCAN
        send(32'hDEAD_BEEF);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_mid_busy",      {31'd0, busy},      32'd0);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_flags",     {28'd0, out_flags}, 32'd0);
`ifdef NA_POPCOUNT_EN
        chk("rst_mid_popcnt",    {26'd0, out_popcnt}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_stale_valid", {31'd0, out_valid}, 32'd0);

        // Randomized operands with random backpressure
        ready_mode = 0;
        for (int n = 0; n < 25; n++) begin
            case ($urandom % 4)
                0:       r = 32'd1 << ($urandom % 32);
                1:       r = $urandom % 16;
                default: r = $urandom;
            endcase
            send(r);
        end
        ready_mode = 2;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/number_analyzer_ctrl.md
NUMBER_ANALYZER_CTRL -- requirements
Module: number_analyzer_ctrl

Interface
REQ-001 The block SHALL expose these ports, one per line: name, direction, width, meaning.
  clk  input  1  single clock, all state on rising edge
  rst_n  input  1  reset, asynchronous, active-low
  abort  input  1  synchronous cancel of any operation in flight
  in_valid  input  1  operand offered
  in_ready  output  1  block can accept an operand
  in_data  input  32  operand, unsigned
  out_valid  output  1  result available
  out_ready  input  1  consumer takes the result
  out_flags  output  4  {is_pow2, is_div3, is_odd, is_zero}, bit 3 down to bit 0
  out_popcnt  output  6  count of set bits, 0..32; present only with NA_POPCOUNT_EN
  busy  output  1  high in SCAN or DONE
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-004 In IDLE, in_ready SHALL be 1. In SCAN and DONE, in_ready SHALL be 0.
REQ-005 An operand SHALL be captured on an edge where in_valid=1, in_ready=1 and abort=0; the FSM then SHALL go to SCAN, with the bit index at 31, the mod-3 residue at 0 and the bit count at 0.
REQ-006 SCAN SHALL process one operand bit per cycle, MSB first, over 32 edges: residue <= (2*residue + bit) mod 3; bit count increments when bit=1.
REQ-007 After the edge that processes bit 0, the FSM SHALL enter DONE; out_valid SHALL first be visible 32 cycles after the capture edge.
REQ-008 In DONE, out_valid SHALL be 1, and out_flags and out_popcnt SHALL be held stable until the handshake.
REQ-009 The result flags SHALL be computed as follows:
  is_zero = operand==0
  is_odd = operand bit 0
  is_div3 = final residue==0
  is_pow2 = bit count==1
REQ-010 On an edge where out_valid and out_ready are both 1, the FSM SHALL go to IDLE. in_ready SHALL rise the following cycle. There SHALL be no same-cycle re-accept.
REQ-011 When abort=1 on any edge, the FSM SHALL go to IDLE and clear out_valid, with no result produced. abort SHALL take priority over in_valid and over out_ready.
REQ-012 When not in DONE, out_valid SHALL be 0 and out_flags SHALL be 0.
REQ-013 The bit index SHALL be 5 bits and SHALL never wrap: the transition out of SCAN occurs at index 0.

Reset
REQ-014 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, out_flags=0, out_popcnt=0, and the residue, count and index all cleared.
REQ-015 Reset during SCAN or DONE SHALL discard the operation, and no stale out_valid SHALL follow reset release.

Configuration
REQ-016 The macro NA_POPCOUNT_EN SHALL control the bit count and the out_popcnt port.
  Defined: the bit count is 6 bits, 0..32, and is exposed on out_popcnt.
  Undefined: out_popcnt is absent, and the count is a 2-bit saturating value (0, 1, >=2) used only for is_pow2.
REQ-017 out_flags SHALL be identical in both builds.

Structure
REQ-018 The shared package na_pkg SHALL hold the following:
  state typedef (IDLE/SCAN/DONE)
  flag bit-index constants: ZERO=0, ODD=1, DIV3=2, POW2=3
  the operand width constant, 32
REQ-019 The residue update SHALL be a sub-module, na_mod3_step: inputs residue[1:0] and bit, output next residue; purely combinational.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  Operand 0xFFFFFFFF -> out_flags=4'b0110, out_popcnt=32, out_valid exactly 32 cycles after capture.
  Operand 0x00000000 -> out_flags=4'b0101, out_popcnt=0.
  Operand 0x80000001 -> out_flags=4'b0110, out_popcnt=2. Operand 0x80000000 -> out_flags=4'b1000, out_popcnt=1.
  Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid=1, flags stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
  Abort on the 10th SCAN cycle while in_valid=1 -> IDLE next cycle, no out_valid pulse. Abort and in_valid together in IDLE -> no capture. Next operand 0x00000003 -> out_flags=4'b0110.
  rst_n low mid-SCAN (asynchronous, between edges) -> outputs at reset values immediately. Build without NA_POPCOUNT_EN: the same operands give identical out_flags.
